// File: rtl/uart_rx_os16_if.sv
// Receive stream of uart_rx_os16: show-ahead head-of-FIFO entry with valid/ready.
interface uart_rx_os16_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, m_parity_err, m_frame_err, m_valid, input m_ready);
  modport slave  (input m_data, m_parity_err, m_frame_err, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: 2-of-3 majority sampling, optional parity,
// framing check and a show-ahead receive FIFO with valid/ready and overrun pulse.
module uart_rx_os16 #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_in,
  uart_rx_os16_if.master m,
  output logic           overrun,
  output logic           busy
);
  localparam int unsigned OS_DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam logic [15:0] OS_LAST  = 16'(OS_DIV - 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned EW       = DATA_BITS + 2;
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0] FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic rx_meta, rxs;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  logic [15:0] div_cnt;
  logic        tick;
  assign tick = (div_cnt == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 16'd1;
  end

  // Start detection waits until the line has been seen idle once after reset.
  logic armed;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              armed <= 1'b0;
    else if (tick && rxs) armed <= 1'b1;
  end

  state_t               state, state_nx;
  logic [3:0]           os_cnt, os_cur;
  logic                 samp7, samp8, maj;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 start_det, frame_done, at_mid, at_end;

  // os_cnt holds the count of the previous tick; the start-detect tick is 0.
  assign os_cur = os_cnt + 4'd1;
  assign at_mid = tick && (os_cur == 4'd9);
  assign at_end = tick && (os_cur == 4'd15);
  assign maj    = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE:
        if (tick && !rxs && armed) begin
          state_nx  = S_START;
          start_det = 1'b1;
        end
      S_START:
        if (at_mid && maj) state_nx = S_IDLE;
        else if (at_end)   state_nx = S_DATA;
      S_DATA:
        if (at_end && bit_idx == LAST_BIT)
          state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:
        if (at_end) state_nx = S_STOP;
      S_STOP:
        if (at_mid) begin
          state_nx   = S_IDLE;
          frame_done = 1'b1;
        end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      samp7   <= 1'b1;
      samp8   <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
    end else if (start_det) begin
      os_cnt  <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
    end else if (tick && state != S_IDLE) begin
      os_cnt <= os_cur;
      if (os_cur == 4'd7) samp7 <= rxs;
      if (os_cur == 4'd8) samp8 <= rxs;
      if (os_cur == 4'd9) begin
        if (state == S_DATA)   shreg <= {maj, shreg[DATA_BITS-1:1]};
        if (state == S_PARITY) perr  <= (((^shreg) ^ maj) != (PARITY == 1));
      end
      if (os_cur == 4'd15 && state == S_DATA) bit_idx <= bit_idx + 3'd1;
    end
  end

  assign busy = (state != S_IDLE);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          valid, pop, push;
  logic [EW-1:0] head;

  assign valid = (count != '0);
  assign pop   = valid && m.m_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push  = frame_done && ((count < FULL) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= frame_done && !push;
      if (push) begin
        mem[wr_ptr] <= {perr, ~maj, shreg};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign m.m_data       = head[DATA_BITS-1:0];
  assign m.m_frame_err  = head[DATA_BITS];
  assign m.m_parity_err = head[DATA_BITS+1];
  assign m.m_valid      = valid;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: three instances (no/odd/even parity) on gated copies
// of one line driver, checked against a frame-level reference model.
module tb_uart_rx_os16;
  // Scaled-down link: OS_DIV = 8 (128 clk/bit), driver bit slightly long.
  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned BAUD    = 781_250;
  localparam int unsigned OS_DIV  = 8;
  localparam int unsigned BIT_CLK = 129;
  localparam int unsigned DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_drv = 1'b1;
  logic m_ready = 1'b0;
  int   sel = 0;
  logic rx0, rx1, rx2, ovr0, ovr1, ovr2, busy0, busy1, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rx0 = (sel == 0) ? rx_drv : 1'b1;
  assign rx1 = (sel == 1) ? rx_drv : 1'b1;
  assign rx2 = (sel == 2) ? rx_drv : 1'b1;

  uart_rx_os16_if #(.DATA_BITS(8)) if0 ();
  uart_rx_os16_if #(.DATA_BITS(8)) if1 ();
  uart_rx_os16_if #(.DATA_BITS(8)) if2 ();
  assign if0.m_ready = m_ready;
  assign if1.m_ready = m_ready;
  assign if2.m_ready = m_ready;

  uart_rx_os16 #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH))
    u_dut0 (.clk(clk), .rst(rst), .rx_in(rx0), .m(if0), .overrun(ovr0), .busy(busy0));
  uart_rx_os16 #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(DEPTH))
    u_dut1 (.clk(clk), .rst(rst), .rx_in(rx1), .m(if1), .overrun(ovr1), .busy(busy1));
  uart_rx_os16 #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH))
    u_dut2 (.clk(clk), .rst(rst), .rx_in(rx2), .m(if2), .overrun(ovr2), .busy(busy2));

  // Observed stream: every accepted entry as {parity_err, frame_err, data}.
  logic [9:0] obs[$];
  int ovr_cnt = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (if0.m_valid && m_ready) obs.push_back({if0.m_parity_err, if0.m_frame_err, if0.m_data});
    if (if1.m_valid && m_ready) obs.push_back({if1.m_parity_err, if1.m_frame_err, if1.m_data});
    if (if2.m_valid && m_ready) obs.push_back({if2.m_parity_err, if2.m_frame_err, if2.m_data});
    ovr_cnt = ovr_cnt + int'(ovr0) + int'(ovr1) + int'(ovr2);
    if (if0.m_valid || if1.m_valid || if2.m_valid) valid_cnt = valid_cnt + 1;
    if (busy0 || busy1 || busy2) busy_cnt = busy_cnt + 1;
  end

  // Reference parity rule: odd needs an odd count of ones over data+parity bit.
  function automatic logic exp_perr(input int par, input logic [7:0] d, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (par == 0) return 1'b0;
    if (par == 1) return (ones % 2) != 1;
    return (ones % 2) != 0;
  endfunction

  task automatic line_bit(input logic b);
    rx_drv = b;
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_drv = 1'b1;
    repeat (n * BIT_CLK) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_bit);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (sel != 0) line_bit(pbit);
    line_bit(stop_bit);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_drv = 1'b1;
    m_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", if0.m_valid); end
    checks++; if (if1.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", if1.m_valid); end
    checks++; if (if2.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", if2.m_valid); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (if0.m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if0.m_data); end
    checks++; if (if0.m_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", if0.m_parity_err); end
    checks++; if (if0.m_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", if0.m_frame_err); end
    @(posedge clk); #1 rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_basic();
    int base, ov, vc, n;
    sel = 0; m_ready = 1'b1;
    base = obs.size(); ov = ovr_cnt; vc = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    n = obs.size() - base;
    checks++; if (n != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks++; if (obs[base] !== 10'h0A5) begin errors++; $display("FAIL basic_entry: got %h want 0a5", obs[base]); end
    end
    checks++; if (valid_cnt - vc != 1) begin errors++; $display("FAIL basic_valid_len: got %0d want 1", valid_cnt - vc); end
    checks++; if (ovr_cnt != ov) begin errors++; $display("FAIL basic_overrun: got %0d want 0", ovr_cnt - ov); end
  endtask

  task automatic test_parity();
    logic [9:0] expq[$];
    int base, n;
    m_ready = 1'b1;
    base = obs.size();
    for (int p = 2; p >= 1; p--) begin
      sel = p;
      idle_bits(1);
      for (int b = 1; b >= 0; b--) begin
        send_frame(8'h07, logic'(b), 1'b1);
        expq.push_back({exp_perr(p, 8'h07, logic'(b)), 1'b0, 8'h07});
      end
    end
    idle_bits(2);
    n = obs.size() - base;
    checks++; if (n != expq.size()) begin errors++; $display("FAIL parity_count: got %0d want %0d", n, expq.size()); end
    for (int i = 0; i < expq.size() && i < n; i++) begin
      checks++;
      if (obs[base+i] !== expq[i]) begin errors++; $display("FAIL parity_entry%0d: got %h want %h", i, obs[base+i], expq[i]); end
    end
  endtask

  task automatic test_frame_err();
    logic [9:0] expq[$];
    int base, n;
    sel = 0; m_ready = 1'b1;
    idle_bits(1);
    base = obs.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    expq.push_back({1'b0, 1'b1, 8'h3C});
    idle_bits(2);
    send_frame(8'h3C, 1'b0, 1'b1);
    expq.push_back({1'b0, 1'b0, 8'h3C});
    idle_bits(2);
    n = obs.size() - base;
    checks++; if (n != 2) begin errors++; $display("FAIL frame_count: got %0d want 2", n); end
    for (int i = 0; i < 2 && i < n; i++) begin
      checks++;
      if (obs[base+i] !== expq[i]) begin errors++; $display("FAIL frame_entry%0d: got %h want %h", i, obs[base+i], expq[i]); end
    end
  endtask

  task automatic test_glitch();
    int base, ov, bc;
    sel = 0; m_ready = 1'b1;
    base = obs.size(); ov = ovr_cnt; bc = busy_cnt;
    rx_drv = 1'b0;
    repeat (3 * OS_DIV) @(posedge clk);
    rx_drv = 1'b1;
    repeat (16 * OS_DIV) @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy0); end
    checks++; if (busy_cnt == bc) begin errors++; $display("FAIL glitch_start_seen: got 0 busy cycles want >0"); end
    idle_bits(2);
    checks++; if (obs.size() != base) begin errors++; $display("FAIL glitch_push: got %0d entries want 0", obs.size() - base); end
    checks++; if (ovr_cnt != ov) begin errors++; $display("FAIL glitch_overrun: got %0d want 0", ovr_cnt - ov); end
    checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", if0.m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] expq[$];
    int base, ov, exp_ovr, n;
    sel = 0; m_ready = 1'b0;
    base = obs.size(); ov = ovr_cnt; exp_ovr = 0;
    for (int v = 1; v <= 5; v++) begin
      if (v == 5) begin
        checks++; if (ovr_cnt != ov) begin errors++; $display("FAIL b2b_early_overrun: got %0d want 0", ovr_cnt - ov); end
      end
      send_frame(8'(v), 1'b0, 1'b1);
      if (expq.size() < DEPTH) expq.push_back({2'b00, 8'(v)});
      else exp_ovr++;
    end
    idle_bits(1);
    checks++; if (ovr_cnt - ov != exp_ovr) begin errors++; $display("FAIL b2b_overrun: got %0d want %0d", ovr_cnt - ov, exp_ovr); end
    @(negedge clk);
    checks++; if (if0.m_valid !== 1'b1) begin errors++; $display("FAIL b2b_held_valid: got %b want 1", if0.m_valid); end
    checks++; if (if0.m_data !== expq[0][7:0]) begin errors++; $display("FAIL b2b_held_head: got %h want %h", if0.m_data, expq[0][7:0]); end
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (10) @(posedge clk);
    n = obs.size() - base;
    checks++; if (n != expq.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", n, expq.size()); end
    for (int i = 0; i < expq.size() && i < n; i++) begin
      checks++;
      if (obs[base+i] !== expq[i]) begin errors++; $display("FAIL b2b_pop%0d: got %h want %h", i, obs[base+i], expq[i]); end
    end
    @(negedge clk);
    checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", if0.m_valid); end
  endtask

  task automatic test_reset_midframe();
    int base, bc, n;
    sel = 0; m_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1);
    idle_bits(1);
    @(negedge clk);
    checks++; if (if0.m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_preload: got %b want 1", if0.m_valid); end
    // Start bit plus data bits 0..2 of 0x00, then halfway into bit 3.
    rx_drv = 1'b0;
    repeat (4 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", if0.m_valid); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", ovr0); end
    checks++; if (if0.m_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", if0.m_data); end
    checks++; if ({if0.m_parity_err, if0.m_frame_err} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b want 00", {if0.m_parity_err, if0.m_frame_err}); end
    @(posedge clk); #1 rst = 1'b0;
    bc = busy_cnt;
    repeat (2 * BIT_CLK) @(posedge clk);
    checks++; if (busy_cnt != bc) begin errors++; $display("FAIL rstmid_unarmed: got %0d busy cycles want 0", busy_cnt - bc); end
    idle_bits(1);
    m_ready = 1'b1;
    base = obs.size();
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(2);
    n = obs.size() - base;
    checks++; if (n != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks++; if (obs[base] !== 10'h05A) begin errors++; $display("FAIL rstmid_entry: got %h want 05a", obs[base]); end
    end
  endtask

  task automatic test_random();
    logic [9:0] expq[$];
    logic [7:0] d;
    logic pbit, stop_bit;
    int base, ov, n;
    m_ready = 1'b1;
    base = obs.size(); ov = ovr_cnt;
    for (int k = 0; k < 12; k++) begin
      sel = int'($urandom_range(0, 2));
      idle_bits(1);
      d = 8'($urandom);
      pbit = 1'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, stop_bit);
      expq.push_back({exp_perr(sel, d, pbit), ~stop_bit, d});
      if (!stop_bit) idle_bits(2);
    end
    idle_bits(2);
    n = obs.size() - base;
    checks++; if (n != expq.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", n, expq.size()); end
    for (int i = 0; i < expq.size() && i < n; i++) begin
      checks++;
      if (obs[base+i] !== expq[i]) begin errors++; $display("FAIL rand_entry%0d: got %h want %h", i, obs[base+i], expq[i]); end
    end
    checks++; if (ovr_cnt != ov) begin errors++; $display("FAIL rand_overrun: got %0d want 0", ovr_cnt - ov); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
